// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared constants for the register family
package reg_pkg;
    localparam int   DEF_WIDTH = 8;
    localparam int   DEF_DEPTH = 4;
    localparam logic EN_ACTIVE = 1'b0;
endpackage

// File: rtl/reg_word.sv
// rtl/reg_word.sv - one storage word: sync reset, parallel load, shift-left with serial in
module reg_word
    import reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - DEPTH-word register bank with addressed write/shift and registered bypassed read
module reg_bank
    import reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             EWR,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] DATA,
    input  logic             ESH,
    input  logic             SIN,
    input  logic             EDY,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] OUTRESULT,
    output logic             OVALID,
    output logic             SOUT
);

    logic [WIDTH-1:0] words [DEPTH];
    logic [WIDTH-1:0] wr_cur, rd_cur, wr_next, rd_next;
    logic             waddr_ok, raddr_ok, wr_en, sh_en;

    assign wr_en = (EWR == EN_ACTIVE);
    assign sh_en = (ESH == EN_ACTIVE) && !wr_en;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        localparam logic [AW-1:0] IDX = AW'(i);
        reg_word #(.WIDTH(WIDTH)) u_word (
            .clk   (CLOCK),
            .reset (RESET),
            .load  (wr_en && (WADDR == IDX)),
            .shift (sh_en && (WADDR == IDX)),
            .sin   (SIN),
            .data  (DATA),
            .q     (words[i])
        );
    end

    // Address decode by equality keeps out-of-range addresses (non power-of-two DEPTH) reading as zero
    always_comb begin
        wr_cur   = '0;
        rd_cur   = '0;
        waddr_ok = 1'b0;
        raddr_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (WADDR == AW'(i)) begin
                wr_cur   = words[i];
                waddr_ok = 1'b1;
            end
            if (RADDR == AW'(i)) begin
                rd_cur   = words[i];
                raddr_ok = 1'b1;
            end
        end
    end

    always_comb begin
        wr_next = wr_cur;
        if (wr_en) begin
            wr_next = DATA;
        end else if (sh_en) begin
            wr_next = {wr_cur[WIDTH-2:0], SIN};
        end
        rd_next = rd_cur;
        if (raddr_ok && waddr_ok && (RADDR == WADDR)) begin
            rd_next = wr_next;
        end
    end

    assign SOUT = wr_cur[WIDTH-1];

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            OUTRESULT <= '0;
            OVALID    <= 1'b0;
        end else if (EDY == EN_ACTIVE) begin
            OUTRESULT <= rd_next;
            OVALID    <= 1'b1;
        end else begin
            OVALID    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - directed self-checking bench for reg_bank (DEPTH=4 and DEPTH=3 instances)
module tb_reg_bank;
    logic       clk = 1'b0;
    logic       reset;

    logic       a_ewr, a_esh, a_sin, a_edy, a_valid, a_sout;
    logic [1:0] a_waddr, a_raddr;
    logic [7:0] a_data, a_out;

    logic       b_ewr, b_esh, b_sin, b_edy, b_valid, b_sout;
    logic [1:0] b_waddr, b_raddr;
    logic [7:0] b_data, b_out;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(8), .DEPTH(4)) dut_a (
        .CLOCK(clk), .RESET(reset), .EWR(a_ewr), .WADDR(a_waddr), .DATA(a_data),
        .ESH(a_esh), .SIN(a_sin), .EDY(a_edy), .RADDR(a_raddr),
        .OUTRESULT(a_out), .OVALID(a_valid), .SOUT(a_sout)
    );

    reg_bank #(.WIDTH(8), .DEPTH(3)) dut_b (
        .CLOCK(clk), .RESET(reset), .EWR(b_ewr), .WADDR(b_waddr), .DATA(b_data),
        .ESH(b_esh), .SIN(b_sin), .EDY(b_edy), .RADDR(b_raddr),
        .OUTRESULT(b_out), .OVALID(b_valid), .SOUT(b_sout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_ewr = 1'b1; a_esh = 1'b1; a_edy = 1'b1; a_sin = 1'b0;
    endtask

    task automatic a_read(input logic [1:0] addr, input logic [7:0] exp, input string tag);
        a_edy = 1'b0; a_raddr = addr;
        tick();
        check({tag, "_data"}, {24'd0, a_out}, {24'd0, exp});
        check({tag, "_valid"}, {31'd0, a_valid}, 32'd1);
        a_edy = 1'b1;
    endtask

    task automatic b_read(input logic [1:0] addr, input logic [7:0] exp, input string tag);
        b_edy = 1'b0; b_raddr = addr;
        tick();
        check({tag, "_data"}, {24'd0, b_out}, {24'd0, exp});
        check({tag, "_valid"}, {31'd0, b_valid}, 32'd1);
        b_edy = 1'b1;
    endtask

    initial begin
        a_idle(); a_waddr = '0; a_raddr = '0; a_data = '0;
        b_ewr = 1'b1; b_esh = 1'b1; b_edy = 1'b1; b_sin = 1'b0;
        b_waddr = '0; b_raddr = '0; b_data = '0;

        reset = 1'b1;
        tick();
        check("reset_out", {24'd0, a_out}, 32'h00);
        check("reset_valid", {31'd0, a_valid}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) a_read(2'(i), 8'h00, "reset_read");

        a_ewr = 1'b0; a_waddr = 2'd2; a_data = 8'hA5;
        tick();
        a_ewr = 1'b1;
        a_read(2'd2, 8'hA5, "wr2_read2");
        a_read(2'd0, 8'h00, "wr2_read0");
        a_read(2'd1, 8'h00, "wr2_read1");
        a_read(2'd3, 8'h00, "wr2_read3");

        a_ewr = 1'b0; a_waddr = 2'd1; a_data = 8'h3C; a_edy = 1'b0; a_raddr = 2'd1;
        tick();
        check("bypass_wr_data", {24'd0, a_out}, 32'h3C);
        check("bypass_wr_valid", {31'd0, a_valid}, 32'd1);
        a_idle();

        a_ewr = 1'b0; a_waddr = 2'd0; a_data = 8'h81;
        tick();
        a_ewr = 1'b1; a_esh = 1'b0; a_sin = 1'b1; a_edy = 1'b0; a_raddr = 2'd0;
        #1 check("sout_first", {31'd0, a_sout}, 32'd1);
        tick();
        check("shift1_bypass", {24'd0, a_out}, 32'h03);
        a_sin = 1'b0;
        #1 check("sout_second", {31'd0, a_sout}, 32'd0);
        tick();
        check("shift2_bypass", {24'd0, a_out}, 32'h06);
        check("shift2_valid_b2b", {31'd0, a_valid}, 32'd1);
        a_idle();
        a_read(2'd0, 8'h06, "shift_final");

        a_ewr = 1'b0; a_esh = 1'b0; a_sin = 1'b1; a_waddr = 2'd3; a_data = 8'h55;
        tick();
        a_idle();
        a_read(2'd3, 8'h55, "wr_beats_shift");

        b_ewr = 1'b0; b_waddr = 2'd2; b_data = 8'h77;
        tick();
        b_waddr = 2'd3; b_data = 8'h99; b_edy = 1'b0; b_raddr = 2'd3;
        #1 check("oob_sout", {31'd0, b_sout}, 32'd0);
        tick();
        check("oob_rdwr_data", {24'd0, b_out}, 32'h00);
        check("oob_rdwr_valid", {31'd0, b_valid}, 32'd1);
        b_ewr = 1'b1; b_esh = 1'b0; b_sin = 1'b1; b_edy = 1'b1;
        tick();
        b_esh = 1'b1;
        b_read(2'd3, 8'h00, "oob_read3");
        b_read(2'd0, 8'h00, "oob_read0");
        b_read(2'd1, 8'h00, "oob_read1");
        b_read(2'd2, 8'h77, "oob_read2");

        a_read(2'd2, 8'hA5, "hold_read");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_data", {24'd0, a_out}, 32'hA5);
            check("hold_valid", {31'd0, a_valid}, 32'd0);
        end

        reset = 1'b1; a_edy = 1'b0; a_raddr = 2'd2;
        tick();
        check("midreset_data", {24'd0, a_out}, 32'h00);
        check("midreset_valid", {31'd0, a_valid}, 32'd0);
        reset = 1'b0; a_edy = 1'b1;
        a_ewr = 1'b0; a_waddr = 2'd3; a_data = 8'hC3;
        tick();
        a_ewr = 1'b1;
        a_read(2'd2, 8'h00, "post_reset_cleared");
        a_read(2'd3, 8'hC3, "post_reset_write");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
